// File: rtl/interface_botoes.sv
// Button front-end for the memory game: synchronizes and debounces four buttons
// and reports each accepted single-button press as a one-cycle pulse plus its code.
module interface_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       jogada,
  output logic [3:0] jogada_valor,
  output logic       erro_botao,
  output logic [2:0] db_estado
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRANDO    = 3'd1,
    EMITE        = 3'd2,
    INVALIDA     = 3'd3,
    ESPERA_SOLTA = 3'd4,
    FILTRA_SOLTA = 3'd5
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    sync_q;
  logic [3:0]    bs_q;
  logic [3:0]    amostra_q, amostra_d;
  logic [3:0]    valor_q, valor_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer on the raw buttons.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 4'b0000;
      bs_q   <= 4'b0000;
    end else begin
      sync_q <= botoes;
      bs_q   <= sync_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      amostra_q <= 4'b0000;
      valor_q   <= 4'b0000;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      amostra_q <= amostra_d;
      valor_q   <= valor_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state; the counter restarts on every transition and counts while a state holds.
  always_comb begin
    state_d    = state_q;
    amostra_d  = amostra_q;
    valor_d    = valor_q;
    cnt_d      = cnt_q;
    jogada     = 1'b0;
    erro_botao = 1'b0;
    db_estado  = state_q;
    case (state_q)
      OCIOSO: begin
        cnt_d = '0;
        if (habilita && (bs_q != 4'b0000)) begin
          state_d   = FILTRANDO;
          amostra_d = bs_q;
        end
      end
      FILTRANDO: begin
        if (bs_q != amostra_q) begin
          state_d = OCIOSO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if ($onehot(amostra_q)) begin
            state_d = EMITE;
            valor_d = amostra_q;
          end else begin
            state_d = INVALIDA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMITE: begin
        jogada  = 1'b1;
        state_d = ESPERA_SOLTA;
        cnt_d   = '0;
      end
      INVALIDA: begin
        erro_botao = 1'b1;
        state_d    = ESPERA_SOLTA;
        cnt_d      = '0;
      end
      ESPERA_SOLTA: begin
        cnt_d = '0;
        if (bs_q == 4'b0000) state_d = FILTRA_SOLTA;
      end
      FILTRA_SOLTA: begin
        if (bs_q != 4'b0000) begin
          state_d = ESPERA_SOLTA;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = OCIOSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = OCIOSO;
        cnt_d     = '0;
        db_estado = 3'd7;
      end
    endcase
  end

  assign jogada_valor = valor_q;

endmodule
